// File: rtl/frame_mem_arbiter.sv
// Two-requester arbiter for the single frame-memory port: display fetcher D has priority,
// processing engine P gets an anti-starvation slot, and read returns are routed by an owner tag pipeline.
module frame_mem_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 8,
  parameter int ADDR_LIMIT = 49152
) (
  input  logic          clk_FPGA,
  input  logic          rst_n,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic          p_gnt,
  output logic          p_rvalid,
  output logic [DW-1:0] p_rdata,
  output logic          p_err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_q
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX  = STARVE_MAX[SW-1:0];
  localparam logic [AW:0]   LIMIT = ADDR_LIMIT[AW:0];

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SMAX) ? SMAX : v + 1'b1;
  endfunction

  logic [SW-1:0]   starve_q, starve_d;
  logic [AW-1:0]   ram_addr_q, ram_addr_d;
  logic            ram_we_q, ram_we_d;
  logic [DW-1:0]   ram_wdata_q, ram_wdata_d;
  logic [RD_LAT:0] tag_vld_q, tag_vld_d;
  logic [RD_LAT:0] tag_own_q, tag_own_d;
  logic [RD_LAT:0] tag_zero_q, tag_zero_d;
  logic            d_rvalid_q, d_rvalid_d;
  logic            p_rvalid_q, p_rvalid_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic [DW-1:0]   p_rdata_q, p_rdata_d;
  logic            p_err_q, p_err_d;
  logic            p_wins, acc_d, acc_p, p_ill;

  // Grants are masked while reset is asserted so the whole port reads idle.
  assign p_wins = p_req & (~d_req | (starve_q == SMAX));
  assign p_gnt  = rst_n & p_wins;
  assign d_gnt  = rst_n & d_req & ~p_wins;
  assign acc_d  = d_req & d_gnt;
  assign acc_p  = p_req & p_gnt;
  assign p_ill  = {1'b0, p_addr} >= LIMIT;

  always_comb begin
    starve_d    = '0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_we_d    = acc_p & p_we & ~p_ill;
    p_err_d     = acc_p & p_ill;
    d_rdata_d   = d_rdata_q;
    p_rdata_d   = p_rdata_q;

    if (p_req && !p_gnt) starve_d = sat_inc(starve_q);

    if (acc_d) begin
      ram_addr_d = d_addr;
    end else if (acc_p) begin
      ram_addr_d = p_addr;
      if (p_we) ram_wdata_d = p_wdata;
    end

    // Stage 0 is the issue cycle; stage RD_LAT lines up with ram_q for that access.
    tag_vld_d  = {tag_vld_q[RD_LAT-1:0],  acc_d | (acc_p & ~p_we)};
    tag_own_d  = {tag_own_q[RD_LAT-1:0],  acc_p};
    tag_zero_d = {tag_zero_q[RD_LAT-1:0], acc_p & p_ill};

    d_rvalid_d = tag_vld_q[RD_LAT] & ~tag_own_q[RD_LAT];
    p_rvalid_d = tag_vld_q[RD_LAT] &  tag_own_q[RD_LAT];
    if (d_rvalid_d) d_rdata_d = ram_q;
    if (p_rvalid_d) p_rdata_d = tag_zero_q[RD_LAT] ? '0 : ram_q;
  end

  always_ff @(posedge clk_FPGA or negedge rst_n) begin
    if (!rst_n) begin
      starve_q    <= '0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      tag_vld_q   <= '0;
      tag_own_q   <= '0;
      tag_zero_q  <= '0;
      d_rvalid_q  <= 1'b0;
      p_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      p_rdata_q   <= '0;
      p_err_q     <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      tag_vld_q   <= tag_vld_d;
      tag_own_q   <= tag_own_d;
      tag_zero_q  <= tag_zero_d;
      d_rvalid_q  <= d_rvalid_d;
      p_rvalid_q  <= p_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      p_rdata_q   <= p_rdata_d;
      p_err_q     <= p_err_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign p_rvalid  = p_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign p_rdata   = p_rdata_q;
  assign p_err     = p_err_q;

endmodule

// File: tb/tb_frame_mem_arbiter.sv
// Bench for frame_mem_arbiter: directed scenarios plus randomized contention checked
// against a transaction-level model (loss counter, return queue keyed by due cycle).
module tb_frame_mem_arbiter;
  localparam int AW = 16, DW = 64, RD_LAT = 2, SMAX = 8, LIMIT = 49152;
  localparam int RET = RD_LAT + 2;

  logic          clk_FPGA = 1'b0;
  logic          rst_n = 1'b0;
  logic          d_req = 1'b0, p_req = 1'b0, p_we = 1'b0;
  logic [AW-1:0] d_addr = '0, p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          d_gnt, d_rvalid, p_gnt, p_rvalid, p_err, ram_we;
  logic [DW-1:0] d_rdata, p_rdata, ram_wdata, ram_q;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] q_pipe [RD_LAT];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk_FPGA = ~clk_FPGA;

  frame_mem_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(SMAX), .ADDR_LIMIT(LIMIT)) dut (
    .clk_FPGA(clk_FPGA), .rst_n(rst_n),
    .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata), .p_gnt(p_gnt),
    .p_rvalid(p_rvalid), .p_rdata(p_rdata), .p_err(p_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_q(ram_q)
  );

  // Memory model: returns the address it was given, RD_LAT cycles later.
  initial for (int k = 0; k < RD_LAT; k++) q_pipe[k] = '0;
  always @(posedge clk_FPGA) begin
    q_pipe[0] <= ram_addr;
    for (int k = 1; k < RD_LAT; k++) q_pipe[k] <= q_pipe[k-1];
  end
  assign ram_q = {{(DW-AW){1'b0}}, q_pipe[RD_LAT-1]};

  function automatic logic [DW-1:0] zx(input logic [AW-1:0] a);
    return {{(DW-AW){1'b0}}, a};
  endfunction

  task automatic test_reset();
    logic [2*DW+AW+DW+6:0] all_out;
    rst_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_FPGA);
      d_req = 1'($urandom); p_req = 1'($urandom); p_we = 1'($urandom);
      d_addr = 16'($urandom); p_addr = 16'($urandom); p_wdata = {$urandom, $urandom};
      #1;
      all_out = {d_gnt, d_rvalid, d_rdata, p_gnt, p_rvalid, p_rdata, p_err, ram_addr, ram_we, ram_wdata};
      total_cnt++; if (all_out !== '0) $display("FAIL reset_outputs: got %h want 0", all_out); else pass_cnt++;
    end
    @(negedge clk_FPGA);
    d_req = 0; p_req = 0; p_we = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_FPGA); #1;
      total_cnt++;
      if ({d_rvalid, p_rvalid, ram_we} !== 3'b000) $display("FAIL reset_release: got %b want 000", {d_rvalid, p_rvalid, ram_we});
      else pass_cnt++;
    end
  endtask

  task automatic test_d_read();
    @(negedge clk_FPGA);
    d_req = 1; d_addr = 16'h6000; #1;
    total_cnt++; if ({d_gnt, p_gnt} !== 2'b10) $display("FAIL d_read_gnt: got %b want 10", {d_gnt, p_gnt}); else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_FPGA);
      d_req = 0; #1;
      if (k == 1) begin
        total_cnt++; if (ram_addr !== 16'h6000) $display("FAIL d_read_addr: got %h want 6000", ram_addr); else pass_cnt++;
        total_cnt++; if (ram_we !== 1'b0) $display("FAIL d_read_we: got %b want 0", ram_we); else pass_cnt++;
      end
      total_cnt++;
      if (d_rvalid !== (k == 4)) $display("FAIL d_read_rvalid k=%0d: got %b want %b", k, d_rvalid, (k == 4));
      else pass_cnt++;
      if (k >= 4) begin
        total_cnt++; if (d_rdata !== zx(16'h6000)) $display("FAIL d_read_rdata k=%0d: got %h want 6000", k, d_rdata); else pass_cnt++;
      end
    end
  endtask

  task automatic test_starvation();
    int nd = 0, np = 0;
    for (int i = 0; i < 33; i++) begin
      @(negedge clk_FPGA);
      d_req = (i < 27); p_req = (i < 27); p_we = 0;
      d_addr = 16'h6100; p_addr = 16'h8200; #1;
      if (i < 27) begin
        total_cnt++;
        if ({d_gnt, p_gnt} !== ((i % 9 == 8) ? 2'b01 : 2'b10))
          $display("FAIL starve_gnt i=%0d: got %b want %b", i, {d_gnt, p_gnt}, ((i % 9 == 8) ? 2'b01 : 2'b10));
        else pass_cnt++;
      end
      if (d_rvalid) begin
        nd++;
        total_cnt++; if (d_rdata !== zx(16'h6100)) $display("FAIL starve_d_rdata: got %h want 6100", d_rdata); else pass_cnt++;
      end
      if (p_rvalid) begin
        np++;
        total_cnt++; if (p_rdata !== zx(16'h8200)) $display("FAIL starve_p_rdata: got %h want 8200", p_rdata); else pass_cnt++;
      end
    end
    total_cnt++; if (nd !== 24) $display("FAIL starve_d_count: got %0d want 24", nd); else pass_cnt++;
    total_cnt++; if (np !== 3) $display("FAIL starve_p_count: got %0d want 3", np); else pass_cnt++;
  endtask

  task automatic test_p_write();
    @(negedge clk_FPGA);
    p_req = 1; p_we = 1; p_addr = 16'h8000; p_wdata = 64'hDEADBEEF00112233; #1;
    total_cnt++; if (p_gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", p_gnt); else pass_cnt++;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_FPGA);
      p_req = 0; p_we = 0; #1;
      total_cnt++; if (ram_we !== (k == 1)) $display("FAIL wr_we k=%0d: got %b want %b", k, ram_we, (k == 1)); else pass_cnt++;
      total_cnt++; if ({p_rvalid, p_err} !== 2'b00) $display("FAIL wr_rv_err k=%0d: got %b want 00", k, {p_rvalid, p_err}); else pass_cnt++;
      if (k == 1) begin
        total_cnt++; if (ram_addr !== 16'h8000) $display("FAIL wr_addr: got %h want 8000", ram_addr); else pass_cnt++;
        total_cnt++; if (ram_wdata !== 64'hDEADBEEF00112233) $display("FAIL wr_data: got %h want deadbeef00112233", ram_wdata); else pass_cnt++;
      end
    end
  endtask

  task automatic test_illegal();
    for (int op = 0; op < 2; op++) begin
      @(negedge clk_FPGA);
      p_req = 1; p_we = (op == 0); p_addr = 16'hC000; p_wdata = 64'h1; #1;
      total_cnt++; if (p_gnt !== 1'b1) $display("FAIL ill_gnt op=%0d: got %b want 1", op, p_gnt); else pass_cnt++;
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk_FPGA);
        p_req = 0; p_we = 0; #1;
        total_cnt++; if (p_err !== (k == 1)) $display("FAIL ill_err op=%0d k=%0d: got %b want %b", op, k, p_err, (k == 1)); else pass_cnt++;
        total_cnt++; if (ram_we !== 1'b0) $display("FAIL ill_we op=%0d k=%0d: got %b want 0", op, k, ram_we); else pass_cnt++;
        total_cnt++;
        if (p_rvalid !== (op == 1 && k == 4)) $display("FAIL ill_rvalid op=%0d k=%0d: got %b want %b", op, k, p_rvalid, (op == 1 && k == 4));
        else pass_cnt++;
        if (op == 1 && k >= 4) begin
          total_cnt++; if (p_rdata !== '0) $display("FAIL ill_rdata k=%0d: got %h want 0", k, p_rdata); else pass_cnt++;
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk_FPGA);
    d_req = 1; d_addr = 16'h6010;
    @(negedge clk_FPGA);
    d_addr = 16'h6020;
    @(negedge clk_FPGA);
    d_req = 0; rst_n = 1'b0; #1;
    total_cnt++;
    if ({ram_addr, d_rdata, p_rdata, d_rvalid, d_gnt} !== '0)
      $display("FAIL midrst_outputs: got addr=%h drd=%h prd=%h", ram_addr, d_rdata, p_rdata);
    else pass_cnt++;
    @(negedge clk_FPGA);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_FPGA); #1;
      total_cnt++; if (d_rvalid !== 1'b0) $display("FAIL midrst_rvalid k=%0d: got %b want 0", k, d_rvalid); else pass_cnt++;
    end
  endtask

  typedef struct { int due; bit own; logic [DW-1:0] val; } ret_t;

  task automatic test_random();
    ret_t rq[$];
    int lost = 0;
    bit d_pend = 0, p_pend = 0, dw, pw, ev_d, ev_p;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_drd = '0, e_prd = '0;
    logic e_we = 0, e_err = 0;
    for (int t = 0; t < 420; t++) begin
      @(negedge clk_FPGA);
      if (!d_pend) begin
        d_req = (t < 400) && ($urandom_range(0, 2) != 0);
        d_addr = 16'($urandom_range(16'h6000, 16'hBFFF));
      end
      if (!p_pend) begin
        p_req = (t < 400) && ($urandom_range(0, 2) != 0);
        p_we = 1'($urandom);
        p_addr = 16'($urandom_range(16'h6000, 16'hFFFF));
        p_wdata = {$urandom, $urandom};
      end
      d_pend = d_req; p_pend = p_req;
      #1;
      pw = p_req && (!d_req || lost == SMAX);
      dw = d_req && !pw;
      total_cnt++; if ({d_gnt, p_gnt} !== {dw, pw}) $display("FAIL rnd_gnt t=%0d: got %b want %b", t, {d_gnt, p_gnt}, {dw, pw}); else pass_cnt++;
      total_cnt++;
      if ({ram_we, p_err, ram_addr, ram_wdata} !== {e_we, e_err, e_addr, e_wdata})
        $display("FAIL rnd_issue t=%0d: got we=%b err=%b a=%h wd=%h want we=%b err=%b a=%h wd=%h",
                 t, ram_we, p_err, ram_addr, ram_wdata, e_we, e_err, e_addr, e_wdata);
      else pass_cnt++;
      ev_d = 0; ev_p = 0;
      if (rq.size() > 0 && rq[0].due == t) begin
        if (rq[0].own) begin ev_p = 1; e_prd = rq[0].val; end
        else begin ev_d = 1; e_drd = rq[0].val; end
        void'(rq.pop_front());
      end
      total_cnt++;
      if ({d_rvalid, p_rvalid, d_rdata, p_rdata} !== {ev_d, ev_p, e_drd, e_prd})
        $display("FAIL rnd_return t=%0d: got v=%b%b d=%h p=%h want v=%b%b d=%h p=%h",
                 t, d_rvalid, p_rvalid, d_rdata, p_rdata, ev_d, ev_p, e_drd, e_prd);
      else pass_cnt++;
      e_we  = pw && p_we && (p_addr < LIMIT);
      e_err = pw && (p_addr >= LIMIT);
      if (dw) begin
        e_addr = d_addr;
        rq.push_back('{t + RET, 1'b0, zx(d_addr)});
      end else if (pw) begin
        e_addr = p_addr;
        if (p_we) e_wdata = p_wdata;
        else rq.push_back('{t + RET, 1'b1, (p_addr >= LIMIT) ? '0 : zx(p_addr)});
      end
      lost = (p_req && !pw) ? ((lost < SMAX) ? lost + 1 : SMAX) : 0;
      if (dw) d_pend = 0;
      if (pw) p_pend = 0;
    end
    total_cnt++; if (rq.size() != 0) $display("FAIL rnd_drain: got %0d pending want 0", rq.size()); else pass_cnt++;
    d_req = 0; p_req = 0;
  endtask

  initial begin
    test_reset();
    test_d_read();
    test_starvation();
    test_p_write();
    test_illegal();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
